// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point result path.
//   norm_state_e : normalizer FSM state encoding (IDLE / NORM / DONE)
//   sig_width()  : working significand width for a given stored fraction width
//   hidden_pos() : bit index of the hidden (integer) bit within that significand
//   lzc_width()  : width of a leading-zero count over an n-bit vector
package fp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } norm_state_e;

    // Product-style significand: two integer bits above a double-width fraction.
    function automatic int unsigned sig_width(input int unsigned mant_w);
        return 2 * mant_w + 2;
    endfunction

    function automatic int unsigned hidden_pos(input int unsigned mant_w);
        return 2 * mant_w;
    endfunction

    function automatic int unsigned lzc_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/leading_zero_counter.sv
// Leading-zero counter.
//   value_i : WIDTH-bit vector to scan, MSB first
//   count_o : number of zero bits above the most significant one (WIDTH when value_i is 0)
module leading_zero_counter
    import fp_pkg::*;
#(
    parameter int unsigned WIDTH = 48,
    localparam int unsigned CNT_W = lzc_width(WIDTH)
) (
    input  logic [WIDTH-1:0] value_i,
    output logic [CNT_W-1:0] count_o
);

    logic found;

    always_comb begin
        count_o = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found) begin
                if (value_i[WIDTH-1-i]) begin
                    found = 1'b1;
                end else begin
                    count_o = count_o + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/result_normalizer.sv
// Result normalizer: takes an unnormalized significand in [0,4) with a biased
// exponent, normalizes it (right by one with sticky, or left down to the
// hidden bit / minimum exponent) and packs exponent, mantissa and
// guard/round/sticky bits for a downstream rounder.
//
// Ports
//   clk, rst_n                 : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready        : input handshake, in_ready only in IDLE
//   in_exponent                : biased exponent, 0 treated as 1
//   in_significand             : SIG_WIDTH bits, binary point below bit H
//   out_valid / out_ready      : output handshake, out_valid only in DONE
//   non_rounded_exponent       : packed exponent (0 for subnormal, all-ones on overflow)
//   non_rounded_mantissa       : packed fraction
//   rounding_bits              : guard/round bits, LSB = sticky
//   overflow_flag, zero_flag   : result flags, only nonzero while out_valid
//
// Build option: define RESULT_NORMALIZER_LZC_EN to perform the whole left
// normalization in a single NORM cycle using a leading-zero counter; packed
// results are identical either way, only latency changes.
module result_normalizer
    import fp_pkg::*;
#(
    parameter int unsigned EXPONENT_WIDTH = 8,
    parameter int unsigned MANTISSA_WIDTH = 23,
    parameter int unsigned ROUNDING_BITS  = 3,
    localparam int unsigned SIG_WIDTH     = sig_width(MANTISSA_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXPONENT_WIDTH:0]   in_exponent,
    input  logic [SIG_WIDTH-1:0]      in_significand,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXPONENT_WIDTH-1:0] non_rounded_exponent,
    output logic [MANTISSA_WIDTH-1:0] non_rounded_mantissa,
    output logic [ROUNDING_BITS-1:0]  rounding_bits,
    output logic                      overflow_flag,
    output logic                      zero_flag
);

    localparam int unsigned H     = hidden_pos(MANTISSA_WIDTH);
    // One extra bit over the input exponent absorbs the +1 of a right shift.
    localparam int unsigned XW    = EXPONENT_WIDTH + 2;
    // Fraction bits below guard/round that collapse into sticky.
    localparam int unsigned LOW_W = MANTISSA_WIDTH - ROUNDING_BITS + 1;

    localparam logic [XW-1:0] EXP_ONE = XW'(1);
    localparam logic [XW-1:0] EXP_SAT = {2'b00, {EXPONENT_WIDTH{1'b1}}};

    norm_state_e               state_q, state_d;
    logic [SIG_WIDTH-1:0]      sig_q, sig_d;
    logic [XW-1:0]             exp_q, exp_d;
    logic [EXPONENT_WIDTH-1:0] oexp_q, oexp_d;
    logic [MANTISSA_WIDTH-1:0] mant_q, mant_d;
    logic [ROUNDING_BITS-1:0]  rb_q, rb_d;
    logic                      ovf_q, ovf_d;
    logic                      zero_q, zero_d;

    logic [H-1:0]              frac;
    logic [MANTISSA_WIDTH-1:0] pack_mant;
    logic [ROUNDING_BITS-1:0]  pack_rb;
    logic [SIG_WIDTH-1:0]      sig_shl;
    logic [XW-1:0]             exp_shl;

    assign frac      = sig_q[H-1:0];
    assign pack_mant = frac[H-1 -: MANTISSA_WIDTH];
    assign pack_rb   = {frac[H-1-MANTISSA_WIDTH -: ROUNDING_BITS-1], |frac[LOW_W-1:0]};

`ifdef RESULT_NORMALIZER_LZC_EN
    localparam int unsigned CNT_W = lzc_width(SIG_WIDTH);
    localparam int unsigned WW    = (CNT_W > XW) ? CNT_W : XW;

    logic [CNT_W-1:0] lz_cnt;
    logic [WW-1:0]    lz_above_h;
    logic [WW-1:0]    exp_room;
    logic [WW-1:0]    lshift;

    leading_zero_counter #(
        .WIDTH (SIG_WIDTH)
    ) u_lzc (
        .value_i (sig_q),
        .count_o (lz_cnt)
    );

    // Only used when the top bit is clear, so the count always includes bit
    // H+1; drop it to get the zeros at/above the hidden bit. The shift stops
    // early when the exponent would go below 1 (subnormal result).
    always_comb begin
        lz_above_h = WW'(lz_cnt) - WW'(1);
        exp_room   = WW'(exp_q) - WW'(1);
        lshift     = (lz_above_h < exp_room) ? lz_above_h : exp_room;
        sig_shl    = sig_q << lshift;
        exp_shl    = exp_q - XW'(lshift);
    end
`else
    assign sig_shl = {sig_q[SIG_WIDTH-2:0], 1'b0};
    assign exp_shl = exp_q - EXP_ONE;
`endif

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        exp_d   = exp_q;
        oexp_d  = oexp_q;
        mant_d  = mant_q;
        rb_d    = rb_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sig_d   = in_significand;
                    exp_d   = (in_exponent == '0) ? EXP_ONE : XW'(in_exponent);
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (sig_q == '0) begin
                    oexp_d  = '0;
                    mant_d  = '0;
                    rb_d    = '0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (sig_q[SIG_WIDTH-1]) begin
                    // Right shift keeps the dropped bit alive in the sticky position.
                    sig_d = {1'b0, sig_q[SIG_WIDTH-1:2], sig_q[1] | sig_q[0]};
                    exp_d = exp_q + EXP_ONE;
                end else if (!sig_q[H] && (exp_q > EXP_ONE)) begin
                    sig_d = sig_shl;
                    exp_d = exp_shl;
                end else begin
                    zero_d  = 1'b0;
                    state_d = ST_DONE;
                    if (exp_q >= EXP_SAT) begin
                        oexp_d = '1;
                        mant_d = '0;
                        rb_d   = '0;
                        ovf_d  = 1'b1;
                    end else begin
                        oexp_d = sig_q[H] ? exp_q[EXPONENT_WIDTH-1:0] : '0;
                        mant_d = pack_mant;
                        rb_d   = pack_rb;
                        ovf_d  = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sig_q   <= '0;
            exp_q   <= '0;
            oexp_q  <= '0;
            mant_q  <= '0;
            rb_q    <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            exp_q   <= exp_d;
            oexp_q  <= oexp_d;
            mant_q  <= mant_d;
            rb_q    <= rb_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready             = (state_q == ST_IDLE);
    assign out_valid            = (state_q == ST_DONE);
    assign non_rounded_exponent = oexp_q;
    assign non_rounded_mantissa = mant_q;
    assign rounding_bits        = rb_q;
    assign overflow_flag        = ovf_q;
    assign zero_flag            = zero_q;

endmodule

// File: tb/tb_result_normalizer.sv
// Directed self-checking bench for result_normalizer at default parameters
// (EXPONENT_WIDTH=8, MANTISSA_WIDTH=23, ROUNDING_BITS=3, H=46).
// Expected latencies follow RESULT_NORMALIZER_LZC_EN when it is defined.
module tb_result_normalizer;

`ifdef RESULT_NORMALIZER_LZC_EN
    localparam int LAT_LEFT = 2;   // 1<<40, exp 127: one wide shift + pack
    localparam int LAT_SUB  = 2;   // 1<<40, exp 3: one shift of 2 + pack
`else
    localparam int LAT_LEFT = 7;   // six single shifts + pack
    localparam int LAT_SUB  = 3;   // two single shifts + pack
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_exponent;
    logic [47:0] in_significand;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  non_rounded_exponent;
    logic [22:0] non_rounded_mantissa;
    logic [2:0]  rounding_bits;
    logic        overflow_flag;
    logic        zero_flag;

    int errors = 0;
    int checks = 0;

    result_normalizer #(
        .EXPONENT_WIDTH (8),
        .MANTISSA_WIDTH (23),
        .ROUNDING_BITS  (3)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_exponent          (in_exponent),
        .in_significand       (in_significand),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .non_rounded_exponent (non_rounded_exponent),
        .non_rounded_mantissa (non_rounded_mantissa),
        .rounding_bits        (rounding_bits),
        .overflow_flag        (overflow_flag),
        .zero_flag            (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {exponent, mantissa, rounding_bits, overflow, zero}
    function automatic logic [35:0] result_vec();
        return {non_rounded_exponent, non_rounded_mantissa, rounding_bits,
                overflow_flag, zero_flag};
    endfunction

    // Drives one operand and waits (bounded) for out_valid; lat counts edges
    // after the accepting edge, reaching 100 on timeout.
    task automatic send(input logic [47:0] s, input logic [8:0] e, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        in_significand = s;
        in_exponent    = e;
        in_valid       = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [35:0] got;
        #1;
        got = result_vec();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_handshake got in_ready/out_valid=%b want 10", {in_ready, out_valid});
        end
        checks++;
        if (got !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", got);
        end
        #20;
        rst_n = 1'b1;
    endtask

    task automatic test_normalized();
        int lat;
        logic [35:0] got;
        // Accept lands on the first edge after reset release.
        send(48'h4000_0000_0000, 9'd127, lat);
        got = result_vec();
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL normalized_latency got %0d want 1", lat);
        end
        checks++;
        if (got !== {8'd127, 23'd0, 3'b000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL normalized_value got %h want %h", got, {8'd127, 23'd0, 3'b000, 2'b00});
        end
        release_out();
        // Guard/round/sticky extraction.
        send(48'h4000_0060_0001, 9'd127, lat);
        got = result_vec();
        checks++;
        if (got !== {8'd127, 23'd0, 3'b111, 1'b0, 1'b0}) begin
            errors++; $display("FAIL grs_value got %h want %h", got, {8'd127, 23'd0, 3'b111, 2'b00});
        end
        release_out();
        // All mantissa bits set.
        send(48'h7FFF_FF80_0000, 9'd200, lat);
        got = result_vec();
        checks++;
        if (got !== {8'd200, 23'h7FFFFF, 3'b000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mant_ones_value got %h want %h", got, {8'd200, 23'h7FFFFF, 3'b000, 2'b00});
        end
        release_out();
    endtask

    task automatic test_right_shift();
        int lat;
        logic [35:0] got;
        send(48'h8000_0000_0001, 9'd127, lat);
        got = result_vec();
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL rshift_sticky_latency got %0d want 2", lat);
        end
        checks++;
        if (got !== {8'd128, 23'd0, 3'b001, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rshift_sticky_value got %h want %h", got, {8'd128, 23'd0, 3'b001, 2'b00});
        end
        release_out();
        send(48'hC000_0000_0000, 9'd127, lat);
        got = result_vec();
        checks++;
        if (got !== {8'd128, 23'h400000, 3'b000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rshift_mant_value got %h want %h", got, {8'd128, 23'h400000, 3'b000, 2'b00});
        end
        release_out();
    endtask

    task automatic test_left_shift();
        int lat;
        logic [35:0] got;
        send(48'h0100_0000_0000, 9'd127, lat);
        got = result_vec();
        checks++;
        if (lat !== LAT_LEFT) begin
            errors++; $display("FAIL lshift_latency got %0d want %0d", lat, LAT_LEFT);
        end
        checks++;
        if (got !== {8'd121, 23'd0, 3'b000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL lshift_value got %h want %h", got, {8'd121, 23'd0, 3'b000, 2'b00});
        end
        release_out();
    endtask

    task automatic test_subnormal();
        int lat;
        logic [35:0] got;
        send(48'h0100_0000_0000, 9'd3, lat);
        got = result_vec();
        checks++;
        if (lat !== LAT_SUB) begin
            errors++; $display("FAIL subnormal_latency got %0d want %0d", lat, LAT_SUB);
        end
        checks++;
        if (got !== {8'd0, 23'h080000, 3'b000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL subnormal_value got %h want %h", got, {8'd0, 23'h080000, 3'b000, 2'b00});
        end
        release_out();
        // Exponent 0 behaves as 1: no shift possible, packs as subnormal.
        send(48'h2000_0000_0000, 9'd0, lat);
        got = result_vec();
        checks++;
        if ({lat[3:0], got} !== {4'd1, 8'd0, 23'h400000, 3'b000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL exp_zero got lat=%0d val=%h want lat=1 val=%h", lat, got, {8'd0, 23'h400000, 3'b000, 2'b00});
        end
        release_out();
        // One shift brings exp 2 down to 1 before the hidden bit is reached.
        send(48'h1000_0000_0000, 9'd2, lat);
        got = result_vec();
        checks++;
        if ({lat[3:0], got} !== {4'd2, 8'd0, 23'h400000, 3'b000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL exp_two got lat=%0d val=%h want lat=2 val=%h", lat, got, {8'd0, 23'h400000, 3'b000, 2'b00});
        end
        release_out();
    endtask

    task automatic test_zero();
        int lat;
        logic [35:0] got;
        send(48'h0, 9'd127, lat);
        got = result_vec();
        checks++;
        if ({lat[3:0], got} !== {4'd1, 8'd0, 23'd0, 3'b000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL zero_value got lat=%0d val=%h want lat=1 val=%h", lat, got, 36'd1);
        end
        release_out();
        checks++;
        if ({overflow_flag, zero_flag} !== 2'b00) begin
            errors++; $display("FAIL zero_flag_clear got %b want 00", {overflow_flag, zero_flag});
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [35:0] got;
        send(48'hC000_0000_0000, 9'd254, lat);
        got = result_vec();
        checks++;
        if ({lat[3:0], got} !== {4'd2, 8'd255, 23'd0, 3'b000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL overflow_value got lat=%0d val=%h want lat=2 val=%h", lat, got, {8'd255, 23'd0, 3'b000, 2'b10});
        end
        release_out();
        // Largest in-range exponent does not overflow.
        send(48'h4000_0000_0000, 9'd254, lat);
        got = result_vec();
        checks++;
        if (got !== {8'd254, 23'd0, 3'b000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL exp_max_value got %h want %h", got, {8'd254, 23'd0, 3'b000, 2'b00});
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [35:0] want;
        want = {8'd128, 23'h400000, 3'b000, 1'b0, 1'b0};
        send(48'hC000_0000_0000, 9'd127, lat);
        // A competing request stays asserted the whole time, including the release edge.
        in_significand = 48'h0;
        in_exponent    = 9'd5;
        in_valid       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, result_vec()} !== {2'b10, want}) begin
                errors++;
                $display("FAIL hold_cycle%0d got v/r=%b val=%h want v/r=10 val=%h", i, {out_valid, in_ready}, result_vec(), want);
            end
        end
        release_out();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL release_no_accept got v/r=%b want 01", {out_valid, in_ready});
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_norm();
        int lat;
        logic [35:0] got;
        in_significand = 48'h0100_0000_0000;
        in_exponent    = 9'd127;
        in_valid       = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++; $display("FAIL norm_busy got v/r=%b want 00", {out_valid, in_ready});
        end
        #2 rst_n = 1'b0;
        #1;
        got = result_vec();
        checks++;
        if ({out_valid, in_ready, got} !== {2'b01, 36'd0}) begin
            errors++; $display("FAIL async_reset got v/r=%b val=%h want v/r=01 val=0", {out_valid, in_ready}, got);
        end
        #2 rst_n = 1'b1;
        send(48'h4000_0000_0000, 9'd100, lat);
        got = result_vec();
        checks++;
        if ({lat[3:0], got} !== {4'd1, 8'd100, 23'd0, 3'b000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL post_reset got lat=%0d val=%h want lat=1 val=%h", lat, got, {8'd100, 23'd0, 3'b000, 2'b00});
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [35:0] got;
        send(48'h0000_0000_0001, 9'd1, lat);
        got = result_vec();
        checks++;
        if ({lat[3:0], got} !== {4'd1, 8'd0, 23'd0, 3'b001, 1'b0, 1'b0}) begin
            errors++; $display("FAIL tiny_sticky got lat=%0d val=%h want lat=1 val=%h", lat, got, {8'd0, 23'd0, 3'b001, 2'b00});
        end
        release_out();
        send(48'h6000_0000_0000, 9'd10, lat);
        got = result_vec();
        checks++;
        if ({lat[3:0], got} !== {4'd1, 8'd10, 23'h400000, 3'b000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL b2b_second got lat=%0d val=%h want lat=1 val=%h", lat, got, {8'd10, 23'h400000, 3'b000, 2'b00});
        end
        release_out();
    endtask

    initial begin
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_exponent    = '0;
        in_significand = '0;
        out_ready      = 1'b0;
        test_reset();
        test_normalized();
        test_right_shift();
        test_left_shift();
        test_subnormal();
        test_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid_norm();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
